// File: rtl/inst_resp_buffer.sv
// Fetch response buffer: tracks outstanding fetches, discards flushed responses and holds stalled data.
// Optional INST_RESP_DROP_CNT_EN adds a saturating count of discarded responses on drop_cnt_o.
module inst_resp_buffer #(
  parameter int RBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ram_req_i,
  input  logic        inst_sram_addr_ok_i,
  input  logic        inst_sram_data_ok_i,
  input  logic [63:0] inst_sram_rdata_i,
  input  logic        if_fire_i,
  input  logic        excep_flush_i,
  output logic        req_allow_o,
  output logic        inst_sram_data_ok_o,
  output logic [63:0] ram_inst_o,
  output logic        inst_rdata_buffer_ok_o,
  output logic [63:0] inst_rdata_buffer_rdata_o,
  output logic [15:0] drop_cnt_o
);

  localparam int CW = $clog2(RBUF_DEPTH + 1);
  localparam int PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;

  logic [CW-1:0] out_cnt, out_cnt_nx, cancel_cnt, fifo_cnt;
  logic [PW-1:0] head, tail;
  logic [63:0]   fifo_mem [RBUF_DEPTH];
  logic [CW:0]   occupancy;

  logic req_fire, resp, keep, fifo_empty, push, pop;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign req_fire   = inst_ram_req_i & inst_sram_addr_ok_i;
  assign resp       = inst_sram_data_ok_i & (out_cnt != '0);
  assign keep       = resp & (cancel_cnt == '0) & ~excep_flush_i;
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = keep & ~(fifo_empty & if_fire_i);
  assign pop        = if_fire_i & ~fifo_empty & ~excep_flush_i;

  assign out_cnt_nx = out_cnt + CW'(req_fire) - CW'(resp);
  assign occupancy  = {1'b0, out_cnt} + {1'b0, fifo_cnt};

  assign req_allow_o               = (occupancy < (CW+1)'(RBUF_DEPTH)) & ~excep_flush_i;
  assign inst_sram_data_ok_o       = keep & fifo_empty;
  assign ram_inst_o                = inst_sram_rdata_i;
  assign inst_rdata_buffer_ok_o    = ~fifo_empty;
  assign inst_rdata_buffer_rdata_o = fifo_mem[head];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt    <= '0;
      cancel_cnt <= '0;
      fifo_cnt   <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      out_cnt <= out_cnt_nx;
      if (excep_flush_i) begin
        // Everything still in flight after this cycle belongs to flushed fetches.
        cancel_cnt <= out_cnt_nx;
        fifo_cnt   <= '0;
        head       <= tail;
      end else begin
        if (resp && cancel_cnt != '0)
          cancel_cnt <= cancel_cnt - 1'b1;
        if (push && !pop)
          fifo_cnt <= fifo_cnt + 1'b1;
        else if (pop && !push)
          fifo_cnt <= fifo_cnt - 1'b1;
        if (push)
          tail <= ptr_inc(tail);
        if (pop)
          head <= ptr_inc(head);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RBUF_DEPTH; i++)
        fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[tail] <= inst_sram_rdata_i;
    end
  end

`ifdef INST_RESP_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt;

  assign drop = resp & ~keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = 16'h0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && inst_sram_data_ok_i && out_cnt == '0)
      $error("inst_resp_buffer: data_ok with no outstanding request");
  end
`endif

endmodule
